// File: rtl/fx2_cmd_bridge_if.sv
// Bundles the byte-stream signals of fx2_cmd_bridge.
//   host_in_*   : command bytes from the USB OUT endpoint (valid/ready)
//   host_out_*  : reply bytes to the USB IN endpoint (valid/ready, pktend marks last reply byte)
//   cmd_*       : metered command bytes to the register FSM (cmd_wr strobe)
//   reply_*     : reply bytes from the register FSM (rdy/ack handshake, end flag)
//   frame_count : completed command/reply frames
// Modport slave is the bridge's view; modport master is the surrounding logic's view.
interface fx2_cmd_bridge_if;
    logic [7:0]  host_in_data;
    logic        host_in_valid;
    logic        host_in_ready;
    logic [7:0]  host_out_data;
    logic        host_out_valid;
    logic        host_out_ready;
    logic        host_out_pktend;
    logic [7:0]  cmd_in;
    logic        cmd_wr;
    logic [7:0]  reply_out;
    logic        reply_rdy;
    logic        reply_ack;
    logic        reply_end;
    logic [15:0] frame_count;

    modport slave (
        input  host_in_data, host_in_valid, host_out_ready, reply_out, reply_rdy, reply_end,
        output host_in_ready, host_out_data, host_out_valid, host_out_pktend, cmd_in, cmd_wr,
               reply_ack, frame_count
    );

    modport master (
        output host_in_data, host_in_valid, host_out_ready, reply_out, reply_rdy, reply_end,
        input  host_in_ready, host_out_data, host_out_valid, host_out_pktend, cmd_in, cmd_wr,
               reply_ack, frame_count
    );
endinterface

// File: rtl/fx2_cmd_bridge.sv
// Byte-stream bridge between the FX2 USB endpoint logic and the register command FSM.
// Host command bytes are buffered and issued onto cmd_wr/cmd_in one per cycle, metered in
// whole 8-byte frames (AA, type, addr[2], data[4]); after a frame's last byte nothing more is
// issued until the register FSM's final reply byte has been accepted. Reply bytes are buffered
// for the host IN endpoint together with their end-of-reply flag.
// Ports:
//   clk   : system clock, all logic on posedge
//   reset : asynchronous, active-high
//   bus   : fx2_cmd_bridge_if.slave (host_in_*, host_out_*, cmd_*, reply_*, frame_count)
// Parameters:
//   CMD_DEPTH_LOG2   : command FIFO depth = 2**N bytes
//   REPLY_DEPTH_LOG2 : reply FIFO depth = 2**N entries of {end, data}
// Configuration macro FX2_BRIDGE_PKTEND_EN: when defined, host_out_pktend flags the last byte
// of each reply at the FIFO head; otherwise it is tied low (end flags are still stored).
module fx2_cmd_bridge #(
    parameter int unsigned CMD_DEPTH_LOG2   = 4,
    parameter int unsigned REPLY_DEPTH_LOG2 = 4
) (
    input logic             clk,
    input logic             reset,
    fx2_cmd_bridge_if.slave bus
);

    localparam int unsigned CmdDepth = 2 ** CMD_DEPTH_LOG2;
    localparam int unsigned RepDepth = 2 ** REPLY_DEPTH_LOG2;
    localparam logic [CMD_DEPTH_LOG2:0]   CmdPtrInc = {{CMD_DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [REPLY_DEPTH_LOG2:0] RepPtrInc = {{REPLY_DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [7:0] SyncByte = 8'hAA;

    typedef enum logic [1:0] {
        StHunt,
        StBody,
        StWait
    } state_e;

    // ---------------------------------------------------------------------------------------
    // Command FIFO
    // ---------------------------------------------------------------------------------------
    logic [7:0]              cmd_mem [CmdDepth];
    logic [CMD_DEPTH_LOG2:0] cmd_wptr_q, cmd_rptr_q;
    logic                    cmd_full, cmd_empty;
    logic                    cmd_push, cmd_pop;
    logic [7:0]              cmd_head;

    assign cmd_empty = (cmd_wptr_q == cmd_rptr_q);
    assign cmd_full  = (cmd_wptr_q[CMD_DEPTH_LOG2] != cmd_rptr_q[CMD_DEPTH_LOG2]) &&
                       (cmd_wptr_q[CMD_DEPTH_LOG2-1:0] == cmd_rptr_q[CMD_DEPTH_LOG2-1:0]);
    assign cmd_push  = bus.host_in_valid && !cmd_full;
    assign cmd_head  = cmd_mem[cmd_rptr_q[CMD_DEPTH_LOG2-1:0]];

    assign bus.host_in_ready = !cmd_full;

    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_mem[cmd_wptr_q[CMD_DEPTH_LOG2-1:0]] <= bus.host_in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_wptr_q <= '0;
            cmd_rptr_q <= '0;
        end else begin
            if (cmd_push) begin
                cmd_wptr_q <= cmd_wptr_q + CmdPtrInc;
            end
            if (cmd_pop) begin
                cmd_rptr_q <= cmd_rptr_q + CmdPtrInc;
            end
        end
    end

    // ---------------------------------------------------------------------------------------
    // Reply FIFO: entries are {end_flag, data}
    // ---------------------------------------------------------------------------------------
    logic [8:0]                rep_mem [RepDepth];
    logic [REPLY_DEPTH_LOG2:0] rep_wptr_q, rep_rptr_q;
    logic                      rep_full, rep_empty;
    logic                      rep_push, rep_pop;
    logic [8:0]                rep_head;

    assign rep_empty = (rep_wptr_q == rep_rptr_q);
    assign rep_full  = (rep_wptr_q[REPLY_DEPTH_LOG2] != rep_rptr_q[REPLY_DEPTH_LOG2]) &&
                       (rep_wptr_q[REPLY_DEPTH_LOG2-1:0] == rep_rptr_q[REPLY_DEPTH_LOG2-1:0]);
    // Ack looks only at the registered full flag, so a pop on a full FIFO does not let the
    // push through in the same cycle.
    assign rep_push  = bus.reply_rdy && !rep_full;
    assign rep_pop   = !rep_empty && bus.host_out_ready;
    assign rep_head  = rep_mem[rep_rptr_q[REPLY_DEPTH_LOG2-1:0]];

    assign bus.reply_ack      = rep_push;
    assign bus.host_out_valid = !rep_empty;
    assign bus.host_out_data  = rep_head[7:0];
`ifdef FX2_BRIDGE_PKTEND_EN
    assign bus.host_out_pktend = rep_head[8] && !rep_empty;
`else
    assign bus.host_out_pktend = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rep_push) begin
            rep_mem[rep_wptr_q[REPLY_DEPTH_LOG2-1:0]] <= {bus.reply_end, bus.reply_out};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_wptr_q <= '0;
            rep_rptr_q <= '0;
        end else begin
            if (rep_push) begin
                rep_wptr_q <= rep_wptr_q + RepPtrInc;
            end
            if (rep_pop) begin
                rep_rptr_q <= rep_rptr_q + RepPtrInc;
            end
        end
    end

    // ---------------------------------------------------------------------------------------
    // Frame metering FSM
    // ---------------------------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic        cmd_wr_q;
    logic [7:0]  cmd_in_q;
    logic        reply_done;

    assign reply_done = rep_push && bus.reply_end;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        frame_count_d = frame_count_q;
        cmd_pop       = 1'b0;

        unique case (state_q)
            StHunt: begin
                if (!cmd_empty) begin
                    cmd_pop = 1'b1;
                    if (cmd_head == SyncByte) begin
                        state_d = StBody;
                        cnt_d   = 3'd0;
                    end
                end
            end
            StBody: begin
                if (!cmd_empty) begin
                    cmd_pop = 1'b1;
                    if (cnt_q == 3'd6) begin
                        state_d = StWait;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            StWait: begin
                if (reply_done) begin
                    frame_count_d = frame_count_q + 16'd1;
                    state_d       = StHunt;
                    // The returning cycle already behaves as HUNT, so the next byte may go.
                    if (!cmd_empty) begin
                        cmd_pop = 1'b1;
                        if (cmd_head == SyncByte) begin
                            state_d = StBody;
                            cnt_d   = 3'd0;
                        end
                    end
                end
            end
            default: begin
                state_d = StHunt;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StHunt;
            cnt_q         <= 3'd0;
            frame_count_q <= 16'd0;
            cmd_wr_q      <= 1'b0;
            cmd_in_q      <= 8'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            frame_count_q <= frame_count_d;
            cmd_wr_q      <= cmd_pop;
            if (cmd_pop) begin
                cmd_in_q <= cmd_head;
            end
        end
    end

    assign bus.cmd_wr      = cmd_wr_q;
    assign bus.cmd_in      = cmd_in_q;
    assign bus.frame_count = frame_count_q;

endmodule

// File: tb/tb_fx2_cmd_bridge.sv
// Self-checking bench for fx2_cmd_bridge. The bench plays both the USB endpoints and the
// register FSM (which echoes the four data bytes of each 8-byte frame as its reply).
module tb_fx2_cmd_bridge;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    fx2_cmd_bridge_if bus ();

    fx2_cmd_bridge #(
        .CMD_DEPTH_LOG2  (4),
        .REPLY_DEPTH_LOG2(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

`ifdef FX2_BRIDGE_PKTEND_EN
    localparam bit PktEn = 1'b1;
`else
    localparam bit PktEn = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Host-side source and expectations derived from the byte stream the bench sends.
    logic [7:0] src_q[$];
    logic [7:0] exp_cmd[$];
    logic [8:0] exp_out[$];
    int         sp_cnt     = 0;
    int         exp_frames = 0;

    // Register FSM model.
    int         rf_cnt  = 0;
    logic [7:0] rf_buf[8];
    bit         rf_busy = 1'b0;
    logic [8:0] rep_q[$];

    // Stimulus knobs and bookkeeping.
    bit         reply_en   = 1'b1;
    int         out_mode   = 1;
    int         in_gap_pct = 0;
    bit         in_fire, rep_fire, out_fire;
    logic [8:0] rep_fire_val;
    int         cyc = 0, n_cmd = 0, n_in = 0, n_out = 0, n_pktend = 0, n_rep_acked = 0;
    int         last_fire_cyc = 0, last_cmd_cyc = 0;
    bit         obs_ready, obs_cmd_wr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Queue a host byte and work out, from the frame rules, what the host must get back.
    task automatic queue_byte(input logic [7:0] b);
        src_q.push_back(b);
        if (sp_cnt == 0) begin
            if (b == 8'hAA) sp_cnt = 1;
        end else begin
            if (sp_cnt >= 4) exp_out.push_back({sp_cnt == 7, b});
            if (sp_cnt == 7) begin
                sp_cnt = 0;
                exp_frames++;
            end else begin
                sp_cnt++;
            end
        end
    endtask

    task automatic queue_frame(input logic [7:0] typ, input logic [15:0] addr,
                               input logic [31:0] data);
        queue_byte(8'hAA);
        queue_byte(typ);
        queue_byte(addr[7:0]);
        queue_byte(addr[15:8]);
        for (int i = 0; i < 4; i++) queue_byte(data[8*i +: 8]);
    endtask

    task automatic queue_junk(input int n);
        logic [7:0] j;
        for (int i = 0; i < n; i++) begin
            j = 8'($urandom_range(255));
            if (j == 8'hAA) j = 8'h55;
            queue_byte(j);
        end
    endtask

    // Register FSM receiving one command byte.
    task automatic rf_byte(input logic [7:0] b);
        check_eq("cmd_while_replying", 32'(rf_busy), 32'd0);
        if (rf_cnt == 0) begin
            if (b == 8'hAA) rf_cnt = 1;
        end else begin
            rf_buf[rf_cnt] = b;
            rf_cnt++;
            if (rf_cnt == 8) begin
                rf_cnt  = 0;
                rf_busy = 1'b1;
                for (int i = 4; i < 8; i++) rep_q.push_back({i == 7, rf_buf[i]});
            end
        end
    endtask

    // One clock cycle: observe at the negedge, drive, then resolve handshakes for the next edge.
    task automatic step();
        logic [8:0] e;
        @(negedge clk);
        cyc++;
        if (in_fire) void'(src_q.pop_front());
        if (rep_fire) begin
            void'(rep_q.pop_front());
            n_rep_acked++;
            if (rep_fire_val[8]) rf_busy = 1'b0;
        end
        obs_ready  = bus.host_in_ready;
        obs_cmd_wr = bus.cmd_wr;
        if (bus.cmd_wr) begin
            n_cmd++;
            last_cmd_cyc = cyc;
            check_eq("cmd_pending", 32'(exp_cmd.size() > 0), 32'd1);
            if (exp_cmd.size() > 0) check_eq("cmd_in", 32'(bus.cmd_in), 32'(exp_cmd.pop_front()));
            rf_byte(bus.cmd_in);
        end

        bus.host_in_valid = (src_q.size() > 0) && ($urandom_range(99) >= in_gap_pct);
        bus.host_in_data  = 8'h00;
        if (src_q.size() > 0) bus.host_in_data = src_q[0];
        bus.reply_rdy = 1'b0;
        bus.reply_out = 8'h00;
        bus.reply_end = 1'b0;
        if (rep_q.size() > 0) begin
            bus.reply_rdy = reply_en;
            bus.reply_out = rep_q[0][7:0];
            bus.reply_end = rep_q[0][8];
        end
        case (out_mode)
            0:       bus.host_out_ready = 1'b0;
            1:       bus.host_out_ready = 1'b1;
            default: bus.host_out_ready = 1'($urandom_range(1));
        endcase

        #1;
        in_fire = bus.host_in_valid && bus.host_in_ready;
        if (in_fire) begin
            exp_cmd.push_back(bus.host_in_data);
            last_fire_cyc = cyc;
            n_in++;
        end
        rep_fire = bus.reply_rdy && bus.reply_ack;
        rep_fire_val = {bus.reply_end, bus.reply_out};
        out_fire = bus.host_out_valid && bus.host_out_ready;
        if (out_fire) begin
            n_out++;
            if (bus.host_out_pktend) n_pktend++;
            check_eq("out_pending", 32'(exp_out.size() > 0), 32'd1);
            if (exp_out.size() > 0) begin
                e = exp_out.pop_front();
                check_eq("host_out_data", 32'(bus.host_out_data), 32'(e[7:0]));
                check_eq("host_out_pktend", 32'(bus.host_out_pktend), 32'(PktEn & e[8]));
            end
        end
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((src_q.size() > 0 || exp_cmd.size() > 0 || rep_q.size() > 0 ||
                exp_out.size() > 0 || rf_busy || rf_cnt != 0) && k < 3000) begin
            step();
            k++;
        end
        check_eq({tag, "_drained"}, 32'(k < 3000), 32'd1);
        step();
        step();
        check_eq({tag, "_frame_count"}, 32'(bus.frame_count), 32'(exp_frames));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_cmd_wr"}, 32'(bus.cmd_wr), 32'd0);
        check_eq({tag, "_cmd_in"}, 32'(bus.cmd_in), 32'd0);
        check_eq({tag, "_frame_count"}, 32'(bus.frame_count), 32'd0);
        check_eq({tag, "_out_valid"}, 32'(bus.host_out_valid), 32'd0);
        check_eq({tag, "_pktend"}, 32'(bus.host_out_pktend), 32'd0);
        check_eq({tag, "_in_ready"}, 32'(bus.host_in_ready), 32'd1);
    endtask

    initial begin
        int base_cmd, base_pkt, base_rep, base_out, base_in, k;
        bit prev_ready;

        bus.host_in_valid  = 1'b0;
        bus.host_in_data   = 8'h00;
        bus.host_out_ready = 1'b0;
        bus.reply_out      = 8'h00;
        bus.reply_rdy      = 1'b0;
        bus.reply_end      = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("por");
        reset = 1'b0;

        // 1) Basic frame and its echoed reply.
        base_pkt = n_pktend;
        queue_frame(8'h01, 16'h1234, 32'hDEADBEEF);
        drain("t1");
        check_eq("t1_pktends", 32'(n_pktend - base_pkt), PktEn ? 32'd1 : 32'd0);

        // 2) Leading junk is issued in HUNT; empty-idle latency is one cycle after the write.
        queue_byte(8'h00);
        k = 0;
        do begin
            step();
            k++;
        end while (!obs_cmd_wr && k < 20);
        check_eq("t2_latency", 32'(last_cmd_cyc - last_fire_cyc), 32'd2);
        queue_byte(8'h55);
        queue_frame(8'h02, 16'h0010, 32'h04030201);
        drain("t2");

        // 3) Two frames back to back; metering is checked on every cmd_wr.
        base_cmd = n_cmd;
        base_pkt = n_pktend;
        base_out = n_out;
        queue_frame(8'h01, 16'hA5A5, 32'h11223344);
        queue_frame(8'h02, 16'h5A5A, 32'hAABBCCDD);
        drain("t3");
        check_eq("t3_cmd_count", 32'(n_cmd - base_cmd), 32'd16);
        check_eq("t3_out_count", 32'(n_out - base_out), 32'd8);
        check_eq("t3_pktends", 32'(n_pktend - base_pkt), PktEn ? 32'd2 : 32'd0);

        // 4) Host stalls: reply FIFO holds 16 bytes, the 17th is not acked, nothing is lost.
        out_mode = 0;
        base_rep = n_rep_acked;
        base_out = n_out;
        for (int f = 0; f < 5; f++) queue_frame(8'(f), 16'(f * 3), $urandom);
        repeat (200) step();
        check_eq("t4_acked", 32'(n_rep_acked - base_rep), 32'd16);
        check_eq("t4_reply_rdy", 32'(bus.reply_rdy), 32'd1);
        check_eq("t4_reply_ack", 32'(bus.reply_ack), 32'd0);
        check_eq("t4_out_valid", 32'(bus.host_out_valid), 32'd1);
        out_mode = 1;
        drain("t4");
        check_eq("t4_out_count", 32'(n_out - base_out), 32'd20);

        // 5) Replies withheld: command FIFO fills to 16 behind the frame, ready returns one
        //    cycle after the first pop.
        reply_en = 1'b0;
        base_in  = n_in;
        for (int f = 0; f < 4; f++) queue_frame(8'h03, 16'(f), $urandom);
        repeat (60) step();
        check_eq("t5_in_ready", 32'(bus.host_in_ready), 32'd0);
        check_eq("t5_accepted", 32'(n_in - base_in), 32'd24);
        reply_en = 1'b1;
        k = 0;
        prev_ready = 1'b0;
        step();
        while (!obs_cmd_wr && k < 20) begin
            prev_ready = obs_ready;
            step();
            k++;
        end
        check_eq("t5_ready_before_pop", 32'(prev_ready), 32'd0);
        check_eq("t5_ready_after_pop", 32'(obs_ready), 32'd1);
        drain("t5");

        // 6) Reset mid-frame with a reply still buffered, then a fresh frame.
        out_mode = 0;
        base_cmd = n_cmd;
        queue_frame(8'h01, 16'h0001, 32'hCAFEF00D);
        queue_byte(8'hAA);
        queue_byte(8'h02);
        queue_byte(8'h00);
        queue_byte(8'h00);
        k = 0;
        while (n_cmd - base_cmd < 12 && k < 100) begin
            step();
            k++;
        end
        check_eq("t6_pre_reset_cmds", 32'(n_cmd - base_cmd), 32'd12);
        reset = 1'b1;
        bus.host_in_valid  = 1'b0;
        bus.reply_rdy      = 1'b0;
        bus.host_out_ready = 1'b0;
        in_fire = 1'b0;
        rep_fire = 1'b0;
        out_fire = 1'b0;
        src_q.delete();
        exp_cmd.delete();
        exp_out.delete();
        rep_q.delete();
        sp_cnt = 0;
        rf_cnt = 0;
        rf_busy = 1'b0;
        exp_frames = 0;
        #1;
        check_reset_outputs("t6_reset");
        @(negedge clk);
        reset = 1'b0;
        out_mode = 1;
        queue_frame(8'h01, 16'h0002, 32'h87654321);
        drain("t6");

        // Randomised traffic: junk between frames, random gaps and host back-pressure.
        out_mode   = 2;
        in_gap_pct = 30;
        for (int f = 0; f < 25; f++) begin
            queue_junk($urandom_range(2));
            queue_frame(8'($urandom), 16'($urandom), $urandom);
        end
        drain("rand");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
